// File: rtl/dense_argmax.sv
// dense_argmax: captures a logit vector in one beat, scans it one compare per cycle and reports argmax and score
module dense_argmax #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CLASS = 7,
  parameter int IDX_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_WIDTH*NUM_CLASS-1:0] data_i,
  input  logic                       valid_i,
  input  logic                       clr_drop_i,
  output logic [IDX_WIDTH-1:0]       class_o,
  output logic [DATA_WIDTH-1:0]      score_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       drop_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASS - 1);
  logic [0:0] state;
  logic [DATA_WIDTH*NUM_CLASS-1:0] buffer;
  logic [IDX_WIDTH-1:0] ptr, best_idx, nxt_idx;
  logic signed [DATA_WIDTH-1:0] best_val, cur, nxt_val;
  always_comb begin
    cur = buffer[ptr*DATA_WIDTH +: DATA_WIDTH];
    nxt_val = cur > best_val ? cur : best_val;
    nxt_idx = cur > best_val ? ptr : best_idx;
  end
  assign busy_o = state == SCAN;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      buffer <= '0;
      ptr <= '0;
      best_val <= '0;
      best_idx <= '0;
      class_o <= '0;
      score_o <= '0;
      valid_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      // a dropped frame beats a simultaneous clear
      drop_o <= (valid_i && state == SCAN) || (drop_o && !clr_drop_i);
      if (state == IDLE) begin
        if (valid_i) begin
          state <= SCAN;
          buffer <= data_i;
          best_val <= data_i[DATA_WIDTH-1:0];
          best_idx <= '0;
          ptr <= IDX_WIDTH'(1);
        end
      end else begin
        best_val <= nxt_val;
        best_idx <= nxt_idx;
        ptr <= ptr == LAST ? '0 : ptr + 1'b1;
        if (ptr == LAST) begin
          state <= IDLE;
          class_o <= nxt_idx;
          score_o <= nxt_val;
          valid_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: table vectors, hand sequences and random frames against an argmax reference model
module tb_dense_argmax;
  logic clk = 1'b0, rstn = 1'b0, valid_i = 1'b0, clr_drop_i = 1'b0;
  logic [55:0] data_i = '0;
  logic [2:0] class_o;
  logic [7:0] score_o;
  logic valid_o, busy_o, drop_o;
  int tests = 0, failed = 0;
  logic exp_drop = 1'b0;
  logic [2:0] prev_c = '0;
  logic [7:0] prev_s = '0;

  typedef struct {
    logic [55:0] data;
    logic [2:0] cls;
    logic [7:0] score;
  } vec_t;
  vec_t vecs[7];

  dense_argmax dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .clr_drop_i(clr_drop_i),
    .class_o(class_o), .score_o(score_o), .valid_o(valid_o), .busy_o(busy_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] pk(input int a0, a1, a2, a3, a4, a5, a6);
    logic [7:0] b[7];
    b = '{8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6)};
    pk = '0;
    for (int k = 0; k < 7; k++) pk[k*8 +: 8] = b[k];
  endfunction

  // argmax with lowest-index tie break, computed on plain integers
  task automatic ref_model(input logic [55:0] d, output logic [2:0] c, output logic [7:0] s);
    int best;
    logic signed [7:0] t;
    best = -1000;
    c = '0;
    for (int k = 0; k < 7; k++) begin
      t = d[k*8 +: 8];
      if (int'(t) > best) begin
        best = int'(t);
        c = 3'(k);
      end
    end
    s = 8'(best);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts a frame at the current negedge and follows it for 7 cycles.
  // inj/clr: cycle offsets at which an extra valid_i / clr_drop_i is driven (0 = never).
  task automatic run(input logic [55:0] d, input int inj, input int clr,
                     input logic [2:0] ec, input logic [7:0] es, input string nm);
    data_i = d;
    valid_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check({nm, " busy/valid"}, 32'({busy_o, valid_o}), k < 7 ? 32'd2 : 32'd1);
      check({nm, " drop"}, 32'(drop_o), 32'(exp_drop));
      check({nm, " class"}, 32'(class_o), k < 7 ? 32'(prev_c) : 32'(ec));
      check({nm, " score"}, 32'(score_o), k < 7 ? 32'(prev_s) : 32'(es));
      valid_i = k == inj;
      data_i = {7{8'h7f}};
      clr_drop_i = k == clr;
      if (valid_i && k < 7) exp_drop = 1'b1;
      else if (clr_drop_i) exp_drop = 1'b0;
    end
    prev_c = ec;
    prev_s = es;
  endtask

  initial begin
    logic [2:0] rc;
    logic [7:0] rs;
    logic [55:0] rd;
    logic seen;
    vecs[0] = '{pk(5, -3, 20, 7, -128, 19, 0), 3'd2, 8'd20};
    vecs[1] = '{pk(10, 10, -1, 10, 0, 0, 0), 3'd0, 8'd10};
    vecs[2] = '{pk(-5, -5, -5, -5, -5, -5, -4), 3'd6, 8'hfc};
    vecs[3] = '{pk(-128, -128, -128, -128, -128, -128, -128), 3'd0, 8'h80};
    vecs[4] = '{pk(-1, 127, 127, -128, 0, 5, 126), 3'd1, 8'd127};
    vecs[5] = '{pk(0, 0, 0, 0, 0, 0, 1), 3'd6, 8'd1};
    vecs[6] = '{pk(-128, -127, -128, -127, -128, -128, -128), 3'd1, 8'h81};
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({class_o, score_o, valid_o, busy_o, drop_o}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run(vecs[i].data, 0, 0, vecs[i].cls, vecs[i].score, $sformatf("vec%0d", i));
    run(vecs[0].data, 0, 0, vecs[0].cls, vecs[0].score, "b2b first");
    run(vecs[4].data, 0, 0, vecs[4].cls, vecs[4].score, "b2b second");
    run(vecs[0].data, 3, 0, vecs[0].cls, vecs[0].score, "drop set");
    run(vecs[1].data, 0, 2, vecs[1].cls, vecs[1].score, "drop clear");
    run(vecs[2].data, 3, 3, vecs[2].cls, vecs[2].score, "drop vs clear");
    data_i = vecs[4].data;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid-scan reset outputs", 32'({class_o, score_o, valid_o, busy_o, drop_o}), 32'd0);
    rstn = 1'b1;
    exp_drop = 1'b0;
    prev_c = '0;
    prev_s = '0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= valid_o | busy_o;
    end
    check("aborted frame silent", 32'(seen), 32'd0);
    run(vecs[0].data, 0, 0, vecs[0].cls, vecs[0].score, "after reset");
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 7; k++)
        rd[k*8 +: 8] = i[0] ? 8'($urandom_range(0, 3) - 2) : 8'($urandom);
      ref_model(rd, rc, rs);
      run(rd, 0, 0, rc, rs, $sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
